// File: rtl/gshare_predictor_ms.sv
// gshare_predictor_ms: multi-lane gshare conditional branch direction predictor.
//
// A table of saturating counters is indexed by PC[IDX_BITS+1:2] XOR the global
// history register (GHR). Every lane of a fetch packet is predicted in the same
// cycle against the same GHR value. The GHR is updated speculatively from the
// predictions, and is restored from the execute-stage checkpoint on a mispredict.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   lookup_valid        fetch packet present this cycle
//   lookup_pc           PC of lane 0 (lane i at lookup_pc + 4*i)
//   lookup_br_mask      per-lane conditional-branch flag
//   taken_out           per-lane predicted direction (combinational)
//   pred_ghr            history used for this lookup (checkpoint for execute)
//   update_valid        resolved conditional branch from execute
//   update_pc           PC of the resolved branch
//   update_ghr          checkpoint captured when that branch was looked up
//   update_taken        resolved direction
//   update_mispredict   direction was mispredicted (qualified by update_valid)
module gshare_predictor_ms #(
  parameter int unsigned PC_BITS      = 32,
  parameter int unsigned HISTORY_BITS = 2,
  parameter int unsigned TABLE_SIZE   = 256,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned LANES        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lookup_valid,
  input  logic [PC_BITS-1:0]      lookup_pc,
  input  logic [LANES-1:0]        lookup_br_mask,
  output logic [LANES-1:0]        taken_out,
  output logic [HISTORY_BITS-1:0] pred_ghr,
  input  logic                    update_valid,
  input  logic [PC_BITS-1:0]      update_pc,
  input  logic [HISTORY_BITS-1:0] update_ghr,
  input  logic                    update_taken,
  input  logic                    update_mispredict
);

  localparam int unsigned IdxBits = $clog2(TABLE_SIZE);
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;
  localparam logic [CTR_BITS-1:0] CtrMin  = '0;

  logic [CTR_BITS-1:0]     ctr_q [TABLE_SIZE];
  logic [HISTORY_BITS-1:0] ghr_q, ghr_d;

  logic [IdxBits-1:0]      lane_idx [LANES];
  logic [IdxBits-1:0]      upd_idx;
  logic [CTR_BITS-1:0]     upd_cur, upd_nxt;

  // Only the index field of each PC is significant to the predictor.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_BITS-1:IdxBits+2], lookup_pc[1:0],
                            update_pc[PC_BITS-1:IdxBits+2], update_pc[1:0]};

  assign pred_ghr = ghr_q;

  // Lane PC = lookup_pc + 4*i, so its index field is the lane-0 field plus i
  // (carries above the index field are discarded anyway).
  always_comb begin
    taken_out = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_idx[i]  = (lookup_pc[IdxBits+1:2] + IdxBits'(i)) ^ IdxBits'(ghr_q);
      taken_out[i] = ctr_q[lane_idx[i]][CTR_BITS-1] & lookup_br_mask[i];
    end
  end

  // Speculative history: shift in branch-lane predictions in lane order, up to
  // and including the first predicted-taken lane. A mispredict repair wins.
  always_comb begin
    logic [HISTORY_BITS-1:0] shift;
    logic [HISTORY_BITS:0]   ext;
    logic                    stop;
    shift = ghr_q;
    ext   = '0;
    stop  = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lookup_br_mask[i] && !stop) begin
        ext   = {shift, taken_out[i]};
        shift = ext[HISTORY_BITS-1:0];
        stop  = taken_out[i];
      end
    end
    ghr_d = ghr_q;
    if (lookup_valid) begin
      ghr_d = shift;
    end
    if (update_valid && update_mispredict) begin
      ext   = {update_ghr, update_taken};
      ghr_d = ext[HISTORY_BITS-1:0];
    end
  end

  // Saturating counter training.
  always_comb begin
    upd_idx = update_pc[IdxBits+1:2] ^ IdxBits'(update_ghr);
    upd_cur = ctr_q[upd_idx];
    upd_nxt = upd_cur;
    if (update_taken) begin
      if (upd_cur != CtrMax) upd_nxt = upd_cur + CTR_BITS'(1);
    end else begin
      if (upd_cur != CtrMin) upd_nxt = upd_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Lookups read ctr_q directly, so a same-cycle update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TABLE_SIZE); i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else if (update_valid) begin
      ctr_q[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: tb/tb_gshare_predictor_ms.sv
module tb_gshare_predictor_ms;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [1:0]  lookup_br_mask;
  logic [1:0]  taken_out;
  logic [1:0]  pred_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [1:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;

  gshare_predictor_ms #(
    .PC_BITS(32), .HISTORY_BITS(2), .TABLE_SIZE(256), .CTR_BITS(2), .LANES(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .lookup_br_mask   (lookup_br_mask),
    .taken_out        (taken_out),
    .pred_ghr         (pred_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        lv;
    logic [31:0] lpc;
    logic [1:0]  mask;
    logic        uv;
    logic [31:0] upc;
    logic [1:0]  ughr;
    logic        ut;
    logic        um;
    logic [1:0]  et;
    logic [1:0]  eg;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] et;
    logic [1:0] eg;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string n, input logic lv, input logic [31:0] lpc,
                              input logic [1:0] m, input logic uv, input logic [31:0] upc,
                              input logic [1:0] ug, input logic ut, input logic um,
                              input logic [1:0] et, input logic [1:0] eg);
    vec_t v;
    v.name = n; v.lv = lv; v.lpc = lpc; v.mask = m; v.uv = uv; v.upc = upc;
    v.ughr = ug; v.ut = ut; v.um = um; v.et = et; v.eg = eg;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    lookup_valid      = v.lv;
    lookup_pc         = v.lpc;
    lookup_br_mask    = v.mask;
    update_valid      = v.uv;
    update_pc         = v.upc;
    update_ghr        = v.ughr;
    update_taken      = v.ut;
    update_mispredict = v.um;
    e.name = v.name; e.et = v.et; e.eg = v.eg;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.name, "_taken"}, taken_out, e.et);
      check({e.name, "_ghr"}, pred_ghr, e.eg);
    end
  endtask

  // Inputs change at negedge; outputs sampled 1 time unit later, before posedge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    sample();
  endtask

  task automatic idle();
    lookup_valid = 1'b0; lookup_pc = '0; lookup_br_mask = '0;
    update_valid = 1'b0; update_pc = '0; update_ghr = '0;
    update_taken = 1'b0; update_mispredict = 1'b0;
  endtask

  initial begin
    //         name        lv  lpc     m     uv  upc     ughr  ut  um  exp_t exp_g
    vecs.push_back(mk("rst_lookup",  1, 32'h100, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk("upd1",        0, 32'h100, 2'b00, 1, 32'h100, 2'b00, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk("upd2",        0, 32'h100, 2'b00, 1, 32'h100, 2'b00, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk("trained",     0, 32'h100, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk("sat_hi_a",    0, 32'h100, 2'b11, 1, 32'h100, 2'b00, 1, 0, 2'b01, 2'b00));
    vecs.push_back(mk("sat_hi_b",    0, 32'h100, 2'b11, 1, 32'h100, 2'b00, 1, 0, 2'b01, 2'b00));
    vecs.push_back(mk("sat_hi_c",    0, 32'h100, 2'b11, 1, 32'h100, 2'b00, 1, 0, 2'b01, 2'b00));
    vecs.push_back(mk("dec_nt",      0, 32'h100, 2'b11, 1, 32'h100, 2'b00, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk("after_dec",   0, 32'h100, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk("nt_then_t",   1, 32'h0FC, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk("misp_clr",    1, 32'h000, 2'b00, 1, 32'h200, 2'b00, 0, 1, 2'b00, 2'b01));
    vecs.push_back(mk("lane0_t",     1, 32'h100, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk("mask0_hold",  1, 32'h100, 2'b00, 0, 32'h0,   2'b00, 0, 0, 2'b00, 2'b01));
    vecs.push_back(mk("ghr_held",    0, 32'h100, 2'b11, 0, 32'h0,   2'b00, 0, 0, 2'b10, 2'b01));
    vecs.push_back(mk("misp_ovr",    1, 32'h0FC, 2'b11, 1, 32'h300, 2'b10, 1, 1, 2'b00, 2'b01));
    vecs.push_back(mk("misp_ctr",    0, 32'h30C, 2'b01, 0, 32'h0,   2'b00, 0, 0, 2'b01, 2'b01));
    vecs.push_back(mk("misp_noval",  0, 32'h000, 2'b00, 0, 32'h300, 2'b11, 1, 1, 2'b00, 2'b01));
    vecs.push_back(mk("noval_held",  0, 32'h000, 2'b00, 0, 32'h0,   2'b00, 0, 0, 2'b00, 2'b01));
    vecs.push_back(mk("sat_lo",      0, 32'h000, 2'b00, 1, 32'h200, 2'b00, 0, 0, 2'b00, 2'b01));
    vecs.push_back(mk("inc_a",       0, 32'h000, 2'b00, 1, 32'h200, 2'b00, 1, 0, 2'b00, 2'b01));
    vecs.push_back(mk("inc_b",       0, 32'h000, 2'b00, 1, 32'h200, 2'b00, 1, 0, 2'b00, 2'b01));
    vecs.push_back(mk("sat_lo_chk",  0, 32'h204, 2'b01, 0, 32'h0,   2'b00, 0, 0, 2'b01, 2'b01));

    idle();
    rst_n = 1'b0;
    lookup_pc = 32'h100; lookup_br_mask = 2'b11;
    #3;
    check("in_reset_taken", taken_out, 2'b00);
    check("in_reset_ghr", pred_ghr, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-operation: training and history vanish before any edge.
    @(negedge clk);
    idle();
    lookup_pc = 32'h100; lookup_br_mask = 2'b11;
    #1;
    check("pre_rst_taken", taken_out, 2'b10);
    check("pre_rst_ghr", pred_ghr, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_taken", taken_out, 2'b00);
    check("async_rst_ghr", pred_ghr, 2'b00);
    lookup_pc = 32'h30C; lookup_br_mask = 2'b01;
    #1;
    check("async_rst_ctr", taken_out, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle lookup and update to one entry: lookup sees the old counter.
    apply(mk("same_cyc",  0, 32'h100, 2'b01, 1, 32'h100, 2'b00, 1, 0, 2'b00, 2'b00));
    apply(mk("same_after", 0, 32'h100, 2'b01, 0, 32'h0, 2'b00, 0, 0, 2'b01, 2'b00));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
